mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the fetch port (F stage) and the data port (M stage) of the pipelined ARM core.
- Arbitrates between the two ports, then sequences one variable-latency memory transaction at a time.
- Fixed data-port priority, with a starvation guard for fetch.
- Its per-port stall outputs feed the hazard unit in the same way as StallF/StallD.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- STARVE_LIMIT, 4, consecutive data grants made while fetch waits before fetch is forced to win. Legal range 1..15.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-low reset (0 = reset).
- if_req  input  1  fetch access pending; held until if_valid.
- if_addr  input  AW  fetch address; stable while if_req.
- if_rdata  output  DW  instruction word; valid only with if_valid, else 0.
- if_valid  output  1  fetch completes this cycle.
- if_stall  output  1  if_req & ~if_valid.
- d_req  input  1  data access pending; held until d_valid.
- d_we  input  1  1 = write, 0 = read; stable while d_req.
- d_addr  input  AW  data address.
- d_wdata  input  DW  write data.
- d_rdata  output  DW  load data; mem_rdata when d_valid and the access is a read, else 0.
- d_valid  output  1  data access completes this cycle.
- d_stall  output  1  d_req & ~d_valid.
- mem_req  output  1  registered; memory transaction active.
- mem_we  output  1  registered write strobe.
- mem_addr  output  AW  registered address.
- mem_wdata  output  DW  registered write data.
- mem_rdata  input  DW  memory read data; valid with mem_ready.
- mem_ready  input  1  memory completes the current transaction this cycle.

Behaviour:
- Reset (asynchronous, any time, including mid-transaction):
  - state = IDLE; mem_req, mem_we, mem_addr, mem_wdata = 0; starve_cnt = 0.
  - Any in-flight transaction is abandoned.
  - Consequently if_valid, d_valid = 0 and if_rdata, d_rdata = 0.
- States and transitions:
  - IDLE, BUSY_I, BUSY_D.
  - IDLE: if any request is present, pick a winner. On the next edge, latch that port's addr, we (fetch forces 0) and wdata (fetch forces 0) into mem_*, set mem_req = 1, and go to BUSY_I or BUSY_D.
  - BUSY_x: hold all mem_* outputs stable until mem_ready = 1.
  - In the mem_ready cycle, x_valid = 1 combinationally. On the following edge: mem_req = 0, mem_we = 0, state = IDLE.
- Minimum latency: a request seen in IDLE at cycle t drives mem_req at t+1. If mem_ready is already high at t+1, valid is asserted at t+1. Back-to-back accesses therefore cost 2 cycles each.
- Arbitration (evaluated in IDLE only):
  - Data wins by default.
  - Fetch wins when only if_req is present, or when both request and starve_cnt == STARVE_LIMIT.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on a data grant made while if_req = 1.
  - Clears on every fetch grant.
  - Unchanged otherwise.
- Requester protocol:
  - Each requester drops or replaces its request on the edge after valid.
  - A request still high in the IDLE cycle after completion is treated as a new access.
- Request withdrawal: mem_ready while state = IDLE is ignored. Deasserting x_req while BUSY_x has no effect; the transaction completes and valid still pulses.
- Stall equations: stall = req & ~valid. This is purely combinational, so a port stalls in the very cycle it first requests.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding localparams ST_IDLE = 2'd0, ST_BUSY_I = 2'd1, ST_BUSY_D = 2'd2;
  - the default AW/DW;
  - the STARVE_LIMIT default.
- One natural sub-module: arb_starve_ctr, a saturating counter with inc, clr and at_limit outputs.
- Everything else (FSM, mem_* registers, output muxing) lives in the top.

Test Plan:
- Reset low mid-BUSY_D with mem_req = 1 -> same cycle mem_req = 0, d_valid = 0, d_rdata = 0. After Reset returns high, idle until a new request.
- Lone fetch: if_req = 1, if_addr = 0x10, mem_ready tied high -> cycle t+1 mem_addr = 0x10, mem_we = 0, if_valid = 1, if_rdata = mem_rdata (0xE3A01005). if_stall = 1 at t only.
- Simultaneous if_req and d_req (read, d_addr = 0x100) -> data is granted first, mem_addr = 0x100. Fetch is granted in the IDLE after completion; if_stall stays high throughout.
- Data write: d_we = 1, d_addr = 0x200, d_wdata = 0xDEADBEEF, mem_ready after 3 BUSY cycles -> mem_we/mem_addr/mem_wdata held for 3 cycles, d_valid pulses on the 3rd, d_rdata = 0.
- Starvation: d_req and if_req held high continuously -> exactly 4 data grants, then 1 fetch grant, then data again. starve_cnt sequence 1, 2, 3, 4, 0.
- Withdrawal: drop d_req while BUSY_D -> transaction still completes on mem_ready, d_valid pulses, no new grant issued.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings and defaults for the fetch/data memory port arbiter.
package mem_arb_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSY_I = 2'd1;
    localparam logic [1:0] ST_BUSY_D = 2'd2;

    localparam int unsigned DEF_AW           = 32;
    localparam int unsigned DEF_DW           = 32;
    localparam int unsigned DEF_STARVE_LIMIT = 4;

    // Wide enough for the largest legal starvation limit (15).
    localparam int unsigned STARVE_CW = 4;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        BUSY_I = ST_BUSY_I,
        BUSY_D = ST_BUSY_D
    } arb_state_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of data grants issued while fetch was left waiting.
module arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int unsigned LIMIT = DEF_STARVE_LIMIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    logic [STARVE_CW-1:0] cnt_q;
    logic [STARVE_CW-1:0] cnt_d;

    assign at_limit = (cnt_q == STARVE_CW'(LIMIT));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !at_limit) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch and data ports: data has
// priority, fetch is forced through after STARVE_LIMIT consecutive data wins.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW           = DEF_AW,
    parameter int unsigned DW           = DEF_DW,
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,
    output logic          if_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_valid,
    output logic          d_stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);

    arb_state_e    state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          grant_i;
    logic          grant_d;
    logic          starve_at_limit;

    arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk      (CLK),
        .rst_n    (Reset),
        .inc      (grant_d && if_req),
        .clr      (grant_i),
        .at_limit (starve_at_limit)
    );

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        grant_i     = 1'b0;
        grant_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_req && !(if_req && starve_at_limit)) begin
                    grant_d     = 1'b1;
                    state_d     = BUSY_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                end else if (if_req) begin
                    grant_i     = 1'b1;
                    state_d     = BUSY_I;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                // Address and write data are left in place after completion.
                if (mem_ready) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    assign if_valid = (state_q == BUSY_I) && mem_ready;
    assign d_valid  = (state_q == BUSY_D) && mem_ready;
    assign if_rdata = if_valid ? mem_rdata : '0;
    assign d_rdata  = (d_valid && !mem_we_q) ? mem_rdata : '0;
    assign if_stall = if_req && !if_valid;
    assign d_stall  = d_req && !d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected completions are queued by the
// stimulus and checked in order by an independent monitor.
module tb_mem_port_arbiter;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        if_stall;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        d_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;

    typedef struct {
        bit          port_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   lat = 1;
    int   busy_cnt = 0;

    mem_port_arbiter dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .if_stall  (if_stall),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_valid   (d_valid),
        .d_stall   (d_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return a ^ 32'hE3A01015;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input bit pd, input logic we, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rd);
        exp_t e;
        e.port_d = pd; e.we = we; e.addr = a; e.wdata = wd; e.rdata = rd;
        return e;
    endfunction

    // Memory model: completes after `lat` cycles of mem_req.
    initial forever begin
        @(posedge CLK);
        #1;
        if (mem_req) begin
            busy_cnt++;
            mem_ready = (busy_cnt >= lat);
        end else begin
            busy_cnt  = 0;
            mem_ready = 1'b0;
        end
        mem_rdata = mem_ready ? mem_fn(mem_addr) : '0;
    end

    initial forever begin
        exp_t e;
        @(negedge CLK);
        if (if_valid && d_valid) check("both_valid", 32'd1, 32'd0);
        if (if_valid || d_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("sb_port",  {31'd0, d_valid}, {31'd0, e.port_d});
                check("sb_addr",  mem_addr, e.addr);
                check("sb_we",    {31'd0, mem_we}, {31'd0, e.we});
                check("sb_wdata", mem_wdata, e.wdata);
                check("sb_rdata", d_valid ? d_rdata : if_rdata, e.rdata);
                check("sb_other_rdata", d_valid ? if_rdata : d_rdata, 32'd0);
            end
        end
    end

    task automatic drive_slot();
        @(posedge CLK);
        #2;
    endtask

    task automatic wait_valid(input bit is_d, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge CLK);
            seen = is_d ? d_valid : if_valid;
        end
        if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge CLK);
        check("rst_mem_req",   {31'd0, mem_req}, 32'd0);
        check("rst_mem_we",    {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr",  mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_valids",    {30'd0, if_valid, d_valid}, 32'd0);
        drive_slot();
        Reset = 1'b1;
        drive_slot();

        // Lone fetch with memory ready immediately
        lat = 1;
        sb.push_back(mk(0, 0, 32'h10, 32'h0, 32'hE3A01005));
        if_addr = 32'h10;
        if_req  = 1'b1;
        @(negedge CLK);
        check("lone_stall_t",   {31'd0, if_stall}, 32'd1);
        check("lone_memreq_t",  {31'd0, mem_req}, 32'd0);
        @(negedge CLK);
        check("lone_memreq_t1", {31'd0, mem_req}, 32'd1);
        check("lone_addr",      mem_addr, 32'h10);
        check("lone_valid",     {31'd0, if_valid}, 32'd1);
        check("lone_rdata",     if_rdata, 32'hE3A01005);
        check("lone_stall_t1",  {31'd0, if_stall}, 32'd0);
        drive_slot();
        if_req = 1'b0;
        @(negedge CLK);
        check("lone_memreq_done", {31'd0, mem_req}, 32'd0);

        // Simultaneous requests: data first, fetch after
        drive_slot();
        sb.push_back(mk(1, 0, 32'h100, 32'h0, mem_fn(32'h100)));
        sb.push_back(mk(0, 0, 32'h20, 32'h0, mem_fn(32'h20)));
        if_addr = 32'h20;
        d_addr  = 32'h100;
        d_we    = 1'b0;
        d_wdata = '0;
        if_req  = 1'b1;
        d_req   = 1'b1;
        begin
            bit done = 1'b0;
            for (int i = 0; i < 20 && !done; i++) begin
                @(negedge CLK);
                if (if_valid) begin
                    done = 1'b1;
                end else begin
                    check("sim_if_stall", {31'd0, if_stall}, 32'd1);
                    if (d_valid) begin
                        drive_slot();
                        d_req = 1'b0;
                    end
                end
            end
            if (!done) check("sim_timeout", 32'd0, 32'd1);
        end
        drive_slot();
        if_req = 1'b0;

        // Data write with 3-cycle memory latency
        lat = 3;
        drive_slot();
        sb.push_back(mk(1, 1, 32'h200, 32'hDEADBEEF, 32'h0));
        d_we    = 1'b1;
        d_addr  = 32'h200;
        d_wdata = 32'hDEADBEEF;
        d_req   = 1'b1;
        @(negedge CLK);
        check("wr_memreq_t", {31'd0, mem_req}, 32'd0);
        check("wr_stall_t",  {31'd0, d_stall}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            check("wr_memreq", {31'd0, mem_req}, 32'd1);
            check("wr_memwe",  {31'd0, mem_we}, 32'd1);
            check("wr_addr",   mem_addr, 32'h200);
            check("wr_wdata",  mem_wdata, 32'hDEADBEEF);
            check("wr_valid",  {31'd0, d_valid}, (k == 2) ? 32'd1 : 32'd0);
        end
        drive_slot();
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_wdata = '0;

        // Starvation guard: four data grants, one fetch, then data again
        lat = 1;
        drive_slot();
        for (int k = 0; k < 4; k++) sb.push_back(mk(1, 0, 32'h300, 32'h0, mem_fn(32'h300)));
        sb.push_back(mk(0, 0, 32'h40, 32'h0, mem_fn(32'h40)));
        sb.push_back(mk(1, 0, 32'h300, 32'h0, mem_fn(32'h300)));
        if_addr = 32'h40;
        d_addr  = 32'h300;
        if_req  = 1'b1;
        d_req   = 1'b1;
        begin
            int n = 0;
            for (int i = 0; i < 60 && n < 6; i++) begin
                @(negedge CLK);
                if (if_valid || d_valid) n++;
            end
            if (n < 6) check("starve_timeout", 32'(n), 32'd6);
        end
        drive_slot();
        if_req = 1'b0;
        d_req  = 1'b0;

        // Withdrawal during BUSY_D still completes
        lat = 3;
        drive_slot();
        sb.push_back(mk(1, 0, 32'h400, 32'h0, mem_fn(32'h400)));
        d_addr = 32'h400;
        d_req  = 1'b1;
        drive_slot();
        d_req = 1'b0;
        wait_valid(1'b1, "wd");
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            check("wd_no_grant", {31'd0, mem_req}, 32'd0);
        end

        // Asynchronous reset in the middle of BUSY_D
        lat = 20;
        drive_slot();
        d_addr = 32'h500;
        d_req  = 1'b1;
        drive_slot();
        check("rstmid_busy", {31'd0, mem_req}, 32'd1);
        @(posedge CLK);
        #3;
        Reset = 1'b0;
        d_req = 1'b0;
        #1;
        check("rstmid_memreq", {31'd0, mem_req}, 32'd0);
        check("rstmid_dvalid", {31'd0, d_valid}, 32'd0);
        check("rstmid_drdata", d_rdata, 32'd0);
        drive_slot();
        Reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            check("rstmid_idle", {31'd0, mem_req}, 32'd0);
        end

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
